// File: rtl/rv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv_mem_pkg
//  Description : Shared types and width constants for the unified memory
//                port of the RV32I pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = 4;

  // Owner encoding doubles as the address/wdata mux select.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

endpackage : rv_mem_pkg
`default_nettype wire

// File: rtl/mem_lat_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_lat_timer
//  Description : Loadable down-counter timing one fixed-latency memory
//                access. o_done is high whenever the count is zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_lat_timer #(
  parameter int MEM_LATENCY = 2,
  parameter int CW          = $clog2(MEM_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_done
);

  logic [CW-1:0] r_cnt;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule : mem_lat_timer
`default_nettype wire

// File: rtl/mux2.sv
`default_nettype none
// ============================================================================
//  Module      : mux2
//  Description : Generic 2:1 multiplexer (i_s=0 selects i_a, 1 selects i_b).
//  Revision    : 1.0 - initial release
// ============================================================================
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_s,
  output logic [W-1:0] o_y
);

  assign o_y = i_s ? i_b : i_a;

endmodule : mux2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares the single unified memory port between fetch (IF)
//                and the memory stage (MEM). One access outstanding at a
//                time; data has priority with bounded IF starvation.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import rv_mem_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int STARVE_MAX  = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [BE_W-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_sel,
  output logic            mem_en,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            busy
);

  localparam int             CNT_W  = $clog2(MEM_LATENCY + 1);
  localparam int             STV_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STV_W-1:0] C_SMAX = STV_W'(STARVE_MAX);

  arb_state_e       r_state;
  owner_e           r_owner;
  logic [STV_W-1:0] r_starve_cnt;

  logic             w_tmr_done;
  logic             w_resp_done;
  logic             w_arb_win;
  logic             w_starved;
  logic             w_if_gnt;
  logic             w_d_gnt;
  logic             w_grant;
  logic             w_sel;
  logic [XLEN-1:0]  w_mux_addr;
  logic [XLEN-1:0]  w_mux_wdata;
  logic [XLEN-1:0]  w_zero;

  assign w_zero      = '0;
  assign w_resp_done = (r_state == WAIT) && w_tmr_done;
  // Arbitration only while out of reset, in IDLE or the completing WAIT cycle.
  assign w_arb_win   = rst_n && ((r_state == IDLE) || w_resp_done);
  assign w_starved   = (r_starve_cnt == C_SMAX);

  // Winner selection: data first unless IF has waited STARVE_MAX data grants.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (w_arb_win) begin
      if (if_req && d_req) begin
        if (w_starved) w_if_gnt = 1'b1;
        else           w_d_gnt  = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end else if (d_req) begin
        w_d_gnt = 1'b1;
      end
    end
  end

  assign w_grant = w_if_gnt | w_d_gnt;

  // Mux select follows the winner in the grant cycle, otherwise the owner.
  always_comb begin
    w_sel = (r_owner == OWN_D);
    if (w_grant) w_sel = w_d_gnt;
  end

  // Sequencer state and access owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_IF;
    end else if (w_grant) begin
      r_state <= WAIT;
      r_owner <= w_d_gnt ? OWN_D : OWN_IF;
    end else if (w_resp_done) begin
      r_state <= IDLE;
    end
  end

  // Consecutive data grants taken while a fetch was waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (!if_req || w_if_gnt) begin
      r_starve_cnt <= '0;
    end else if (w_d_gnt && !w_starved) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  mem_lat_timer #(
    .MEM_LATENCY (MEM_LATENCY),
    .CW          (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_grant),
    .i_load_val (C_LOAD),
    .o_done     (w_tmr_done)
  );

  mux2 #(.W(XLEN)) u_addr_mux (
    .i_a (if_addr),
    .i_b (d_addr),
    .i_s (mem_sel),
    .o_y (w_mux_addr)
  );

  // IF never writes, so its write-data leg is tied to zero.
  mux2 #(.W(XLEN)) u_wdata_mux (
    .i_a (w_zero),
    .i_b (d_wdata),
    .i_s (mem_sel),
    .o_y (w_mux_wdata)
  );

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign mem_sel   = w_sel;
  assign mem_en    = w_grant;
  assign mem_we    = w_d_gnt & d_we;
  assign mem_be    = mem_en ? (mem_we ? d_be : {BE_W{1'b1}}) : '0;
  assign mem_addr  = mem_en ? w_mux_addr : '0;
  assign mem_wdata = mem_en ? w_mux_wdata : '0;

  assign if_rvalid = w_resp_done && (r_owner == OWN_IF);
  assign d_rvalid  = w_resp_done && (r_owner == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign busy      = (r_state == WAIT) && !w_tmr_done;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a
//                timestamp-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int L  = 2;
  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be, mem_be;
  logic        mem_sel, mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Requester agents: a request stays pending (and stable) until granted.
  bit          f_pend, d_pend, f_auto, d_auto;
  logic [31:0] f_addr_v, d_addr_v, d_wdata_v;
  logic        d_we_v;
  logic [3:0]  d_be_v;

  // Reference model: port free time, one outstanding response, IF streak.
  int  next_free, resp_cyc, streak;
  bit  resp_live, resp_own, resp_we, last_owner;
  int  g_cyc[$];
  bit  g_own[$];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, ".if_gnt"},    {31'd0, if_gnt},    32'd0);
    check({tag, ".d_gnt"},     {31'd0, d_gnt},     32'd0);
    check({tag, ".if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    check({tag, ".d_rvalid"},  {31'd0, d_rvalid},  32'd0);
    check({tag, ".mem_en"},    {31'd0, mem_en},    32'd0);
    check({tag, ".mem_we"},    {31'd0, mem_we},    32'd0);
    check({tag, ".busy"},      {31'd0, busy},      32'd0);
    check({tag, ".mem_sel"},   {31'd0, mem_sel},   32'd0);
    check({tag, ".mem_be"},    {28'd0, mem_be},    32'd0);
    check({tag, ".mem_addr"},  mem_addr,           32'd0);
    check({tag, ".mem_wdata"}, mem_wdata,          32'd0);
  endtask

  task automatic model_reset();
    next_free  = cyc;
    resp_live  = 0;
    streak     = 0;
    last_owner = 0;
    f_pend = 0; d_pend = 0; f_auto = 0; d_auto = 0;
  endtask

  // One clock cycle: drive at negedge, check mid-low phase, advance.
  task automatic tick();
    bit e_ig, e_dg, e_sel, e_irv, e_drv, e_busy;
    logic [31:0] rd;
    rd = $urandom;
    mem_rdata = rd;
    if_req = f_pend;  if_addr = f_addr_v;
    d_req  = d_pend;  d_we = d_we_v; d_addr = d_addr_v;
    d_wdata = d_wdata_v; d_be = d_be_v;
    #1;
    e_ig = 0; e_dg = 0;
    if (cyc >= next_free) begin
      if (f_pend && d_pend) begin
        if (streak == SM) e_ig = 1; else e_dg = 1;
      end else if (f_pend) e_ig = 1;
      else if (d_pend)     e_dg = 1;
    end
    e_sel  = e_dg ? 1'b1 : (e_ig ? 1'b0 : last_owner);
    e_irv  = resp_live && (resp_cyc == cyc) && !resp_own;
    e_drv  = resp_live && (resp_cyc == cyc) && resp_own;
    e_busy = resp_live && (cyc < resp_cyc);

    check("if_gnt",    {31'd0, if_gnt},    {31'd0, e_ig});
    check("d_gnt",     {31'd0, d_gnt},     {31'd0, e_dg});
    check("mem_en",    {31'd0, mem_en},    {31'd0, e_ig | e_dg});
    check("mem_sel",   {31'd0, mem_sel},   {31'd0, e_sel});
    check("mem_we",    {31'd0, mem_we},    {31'd0, e_dg & d_we_v});
    check("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_irv});
    check("d_rvalid",  {31'd0, d_rvalid},  {31'd0, e_drv});
    check("busy",      {31'd0, busy},      {31'd0, e_busy});
    if (e_ig) begin
      check("mem_addr_if", mem_addr, f_addr_v);
      check("mem_be_if",   {28'd0, mem_be}, 32'h0000_000F);
    end
    if (e_dg) begin
      check("mem_addr_d", mem_addr, d_addr_v);
      check("mem_be_d",   {28'd0, mem_be}, d_we_v ? {28'd0, d_be_v} : 32'h0000_000F);
      if (d_we_v) check("mem_wdata", mem_wdata, d_wdata_v);
    end
    if (e_irv) check("if_rdata", if_rdata, rd);
    if (e_drv && !resp_we) check("d_rdata", d_rdata, rd);

    if (resp_live && resp_cyc == cyc) resp_live = 0;
    if (!f_pend)                  streak = 0;
    else if (e_ig)                streak = 0;
    else if (e_dg && streak < SM) streak++;
    if (e_ig || e_dg) begin
      resp_live  = 1;
      resp_cyc   = cyc + L;
      resp_own   = e_dg;
      resp_we    = e_dg & d_we_v;
      next_free  = cyc + L;
      last_owner = e_dg;
      g_cyc.push_back(cyc);
      g_own.push_back(e_dg);
    end
    if (e_ig) begin
      f_pend = f_auto;
      f_addr_v = f_addr_v + 32'd4;
    end
    if (e_dg) d_pend = d_auto;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int base;
    // Reset asserted at time zero with both requests up: nothing may grant.
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_we = 1'b0;
    d_addr = 32'h80; d_wdata = 32'h0; d_be = 4'h0; mem_rdata = 32'h1234_5678;
    f_addr_v = 0; d_addr_v = 0; d_wdata_v = 0; d_we_v = 0; d_be_v = 0;
    #1;
    check_reset_outputs("rst0");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_outputs("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Single fetch at 0x100.
    f_pend = 1; f_addr_v = 32'h100;
    idle(4);

    // Simultaneous requests: data first, then IF.
    base = g_cyc.size();
    f_pend = 1; f_addr_v = 32'h200;
    d_pend = 1; d_we_v = 0; d_addr_v = 32'h3000;
    idle(7);
    check("simul_first_own",  {31'd0, g_own[base]},   32'd1);
    check("simul_second_own", {31'd0, g_own[base+1]}, 32'd0);
    check("simul_gap",        g_cyc[base+1] - g_cyc[base], 32'd2);

    // Starvation: both held continuously -> D,D,D,IF every 2 cycles.
    base = g_cyc.size();
    f_pend = 1; f_auto = 1; f_addr_v = 32'h400;
    d_pend = 1; d_auto = 1; d_addr_v = 32'h5000; d_we_v = 0;
    idle(7);
    f_auto = 0; d_auto = 0;
    for (int i = 0; i < 4; i++) begin
      check("starve_own", {31'd0, g_own[base+i]}, (i == 3) ? 32'd0 : 32'd1);
      check("starve_cyc", g_cyc[base+i] - g_cyc[base], 32'(2*i));
    end
    idle(8);

    // Store with partial byte enables.
    d_pend = 1; d_we_v = 1; d_be_v = 4'b0011;
    d_addr_v = 32'h2000; d_wdata_v = 32'hDEAD_BEEF;
    idle(4);

    // Reset in cycle 1 of a fetch: access abandoned, no if_rvalid.
    f_pend = 1; f_addr_v = 32'h600; d_we_v = 0;
    tick();
    #2;
    rst_n = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_reset_outputs("rst_mid_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = cyc + 4;
    model_reset();
    base = g_cyc.size();
    d_pend = 1; d_we_v = 0; d_addr_v = 32'h7000;
    tick();
    check("post_rst_dgnt", 32'(g_cyc.size() - base), 32'd1);
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      if (!f_pend && $urandom_range(0, 2) == 0) begin
        f_pend = 1; f_addr_v = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1; d_we_v = $urandom_range(0, 1);
        d_addr_v = $urandom; d_wdata_v = $urandom; d_be_v = 4'($urandom);
      end
      tick();
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mem_port_arbiter
`default_nettype wire
